// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the hyperbolic-vectoring CORDIC sequencer.
//   - FP_POS_ONE / FP_NEG_ONE : IEEE-754 single-precision +1.0 / -1.0
//   - state_t                 : controller FSM states
//   - is_repeat(i)            : true for the shift indices that hyperbolic
//                               CORDIC must issue twice to converge (4, 13)
package cordic_pkg;

  localparam logic [31:0] FP_POS_ONE = 32'h3f800000;
  localparam logic [31:0] FP_NEG_ONE = 32'hbf800000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Members of the 3k+1 sequence (4, 13, 40, ...) below any practical N_ITER.
  function automatic logic is_repeat(input logic [31:0] i);
    return (i == 32'd4) || (i == 32'd13);
  endfunction

endpackage

// File: rtl/cordic_hyp_ctrl_if.sv
// cordic_hyp_ctrl_if
//   Bundles the controller's command-side and datapath-side signals.
//   master : the sequencer (drives busy/ld/step command/done)
//   slave  : the environment (drives start, y_sign, step_ready)
//
//   Handshake: a step command (shift_idx, lut_addr, sigma) is offered while
//   step_valid=1 and is transferred on a rising edge where step_valid=1 and
//   step_ready=1. While step_valid=1 and step_ready=0 the command is held
//   unchanged. step_valid never drops without a transfer except on rst.
//   step_ready is ignored while step_valid=0.
interface cordic_hyp_ctrl_if #(
  parameter int IDX_W = 5
);
  logic             start;
  logic             y_sign;
  logic             busy;
  logic             ld;
  logic             step_valid;
  logic             step_ready;
  logic [IDX_W-1:0] shift_idx;
  logic [IDX_W-1:0] lut_addr;
  logic [31:0]      sigma;
  logic             done;

  modport master (
    input  start, y_sign, step_ready,
    output busy, ld, step_valid, shift_idx, lut_addr, sigma, done
  );

  modport slave (
    output start, y_sign, step_ready,
    input  busy, ld, step_valid, shift_idx, lut_addr, sigma, done
  );
endinterface

// File: rtl/cordic_sigma_sel.sv
// cordic_sigma_sel
//   Combinational rotation-direction selector for hyperbolic vectoring:
//   y negative (sign bit 1) -> +1.0, y non-negative -> -1.0.
//   Ports: y_sign (in, 1), sigma (out, 32, IEEE-754 single).
module cordic_sigma_sel
  import cordic_pkg::*;
(
  input  logic        y_sign,
  output logic [31:0] sigma
);

  assign sigma = y_sign ? FP_POS_ONE : FP_NEG_ONE;

endmodule

// File: rtl/cordic_hyp_ctrl.sv
// cordic_hyp_ctrl
//   Step sequencer for the hyperbolic-vectoring (atanh) CORDIC datapath.
//   On start it pulses ld, then issues one handshaked command per iteration
//   i = 1..N_ITER carrying the shift index, the atanh(2^-i) LUT address and
//   the direction sigma, then pulses done.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     bus        : cordic_hyp_ctrl_if.master (start/y_sign in, busy/ld/
//                  step_valid/shift_idx/lut_addr/sigma/done out,
//                  step_ready in)
//     dbg_state  : current FSM state, for observation only
//
//   Configuration macro CORDIC_REPEAT_EN:
//     defined   -> indices 4 and 13 are issued twice (N_ITER+2 steps for 16)
//     undefined -> strict 1..N_ITER sequence, no repeat bookkeeping
module cordic_hyp_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER = 16,
  parameter int IDX_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  cordic_hyp_ctrl_if.master  bus,
  output state_t             dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITER);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t           state;
  logic             busy_r;
  logic             ld_r;
  logic             valid_r;
  logic             done_r;
  logic [IDX_W-1:0] idx;
  logic [31:0]      sigma_r;
  logic [31:0]      sigma_new;
  logic             hold_idx;   // accepted step must be re-issued at same index

  // sigma for the next step is captured on the edge that starts that step;
  // the datapath has already settled y by the time it releases step_ready.
  cordic_sigma_sel u_sigma_sel (
    .y_sign (bus.y_sign),
    .sigma  (sigma_new)
  );

`ifdef CORDIC_REPEAT_EN
  logic rep_pending;            // first pass of a repeat index already done
  assign hold_idx = is_repeat(32'(idx)) && !rep_pending;
`else
  assign hold_idx = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy_r      <= 1'b0;
      ld_r        <= 1'b0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
      idx         <= '0;
      sigma_r     <= FP_POS_ONE;
`ifdef CORDIC_REPEAT_EN
      rep_pending <= 1'b0;
`endif
    end else begin
      ld_r   <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD;
            busy_r <= 1'b1;
            ld_r   <= 1'b1;
          end
        end
        LOAD: begin
          state   <= ISSUE;
          valid_r <= 1'b1;
          idx     <= ONE_IDX;
          sigma_r <= sigma_new;
`ifdef CORDIC_REPEAT_EN
          rep_pending <= 1'b0;
`endif
        end
        ISSUE: begin
          if (bus.step_ready) begin
            if (hold_idx) begin
`ifdef CORDIC_REPEAT_EN
              rep_pending <= 1'b1;
`endif
              sigma_r <= sigma_new;
            end else if (idx == LAST_IDX) begin
              // idx stays at LAST_IDX: no wrap past the final iteration
              state   <= DONE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              idx     <= idx + ONE_IDX;
              sigma_r <= sigma_new;
`ifdef CORDIC_REPEAT_EN
              rep_pending <= 1'b0;
`endif
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.ld         = ld_r;
  assign bus.step_valid = valid_r;
  assign bus.shift_idx  = idx;
  assign bus.lut_addr   = idx;
  assign bus.sigma      = sigma_r;
  assign bus.done       = done_r;
  assign dbg_state      = state;

endmodule

// File: doc/cordic_hyp_ctrl.md
# cordic_hyp_ctrl

Sequencing controller for the hyperbolic-vectoring CORDIC datapath that computes atanh. It accepts a start request and issues one iteration command per step: shift index, atanh(2^-i) table address and the IEEE-754 single-precision direction value sigma (+1.0/-1.0). Each command is handshaked to the multi-cycle floating-point add/shift datapath. It sits between the top-level command interface and the x/y/z update datapath, and replaces free-running iteration counting.

## Interface
Parameters:
- N_ITER, 16: last shift index i; iterations run i = 1..N_ITER.
- IDX_W, 5: width of shift index and LUT address; must satisfy 2^IDX_W > N_ITER.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new atanh evaluation; sampled only in IDLE.
- y_sign  in  1  sign bit (bit 31) of the datapath's current y register.
- busy  out  1  high from the cycle after start is accepted until done.
- ld  out  1  one-cycle pulse: datapath loads initial x, y, z.
- step_valid  out  1  iteration command valid.
- step_ready  in  1  datapath accepts the command; update is complete when accepted.
- shift_idx  out  IDX_W  current shift amount i.
- lut_addr  out  IDX_W  atanh(2^-i) table address; equals shift_idx.
- sigma  out  32  +1.0 (32'h3f800000) if y_sign=1, -1.0 (32'hbf800000) if y_sign=0.
- done  out  1  one-cycle pulse when the final iteration is accepted.

## Operation
- FSM states: IDLE, LOAD, ISSUE, DONE.
- IDLE: busy=0. start=1 -> LOAD. start in any other state is ignored (no queuing).
- LOAD: ld=1 for exactly one cycle. shift_idx <- 1 and rep_pending <- 0. Next state ISSUE.
- ISSUE: step_valid=1. sigma is computed from y_sign, registered on entry to each step, and held stable with shift_idx while step_valid=1 && step_ready=0.
- On step_valid && step_ready:
  - if shift_idx is a repeat index and rep_pending=0: set rep_pending=1 and keep shift_idx;
  - else if shift_idx == N_ITER: -> DONE;
  - else: shift_idx+1, rep_pending=0.
- DONE: done=1 for one cycle. Next state IDLE.
- Repeat indices are 4 and 13 (3k+1 sequence), so each of them is issued twice. An index greater than N_ITER is never issued.
- Step count for N_ITER=16: 16 + 2 = 18 handshakes.
- sigma is recomputed at each new step from the y_sign value present at that step's first valid cycle. The datapath guarantees y is updated before step_ready is released.
- shift_idx never wraps; it saturates at N_ITER.

## Timing
- Reset values: busy=0, ld=0, step_valid=0, done=0, shift_idx=0, lut_addr=0, sigma=32'h3f800000, state=IDLE.
- start at cycle t -> ld at t+1 -> first step_valid at t+2.
- Each step lasts at least 1 cycle: back-to-back accepts are allowed when step_ready is held high.
- Latency with step_ready tied high: done at t+2+S, where S is the number of steps (18 for N_ITER=16).
- done and busy fall together; start is accepted in the cycle after done.
- rst mid-operation: the next cycle is IDLE with all outputs at their reset values; the in-flight step is abandoned.
- step_ready outside ISSUE is ignored.

## Configuration
- CORDIC_REPEAT_EN defined: repeat iterations at indices 4 and 13, as described above.
- Macro undefined: a strict 1..N_ITER sequence with no repeats (S = N_ITER). The rep_pending flag is removed. Convergence range is reduced; this build is for debug and area comparison only.

## Structure
- Shared package cordic_pkg holds:
  - constants FP_POS_ONE = 32'h3f800000 and FP_NEG_ONE = 32'hbf800000;
  - the state enum;
  - the repeat-index function is_repeat(i).
- One sub-module: cordic_sigma_sel, a combinational y_sign -> ±1.0 selector instantiated inside the controller. The step register sits after it.

## Test plan
- Reset, then idle 5 cycles -> all outputs at reset values; sigma=32'h3f800000.
- N_ITER=16, macro defined, step_ready=1, start pulse at t -> ld at t+1. shift_idx sequence is 1,2,3,4,4,5,…,13,13,14,15,16 (18 steps). done at t+20.
- y_sign toggled 0/1 on alternate steps -> sigma alternates 32'hbf800000 / 32'h3f800000, matching y_sign at each step's first valid cycle.
- step_ready held low 3 cycles on step 5 -> shift_idx=4 (second pass) and sigma held stable; no index advance until accepted.
- start asserted while busy, and rst asserted at step 7 -> the extra start is ignored. On reset, IDLE next cycle with busy=0 and step_valid=0. A new start then runs a full 18 steps.
- Macro undefined, N_ITER=16 -> 16 steps 1..16, no repeats; done at t+18.
